// File: rtl/jtframe_scroll_pkg.sv
// Shared definitions for the 16x16 tile scroll layer: fetch FSM states,
// tile-word field positions, ROM plane layout and a bit-reversal helper.
package jtframe_scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAP  = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    // VRAM tile word: palette sits at the top, then hflip at CODEW, code below
    localparam int TILE_WORD_W  = 16;
    localparam int TILE_PAL_MSB = 15;

    // ROM word: plane p occupies byte p, column i is bit i of that byte
    localparam int ROM_WORD_W   = 32;
    localparam int PLANE_STRIDE = 8;

    // Scroll sum bit positions: bit 3 picks the half-tile, bits 4+ the tile
    localparam int HALF_SHIFT   = 3;
    localparam int TILE_SHIFT   = 4;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram16.sv
// Dual-port 16-bit VRAM: port 0 is read/write with byte enables, port 1 is
// read-only. Both reads are registered, one clk of latency. No reset.
module jtframe_dual_ram16 #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr0,
    input  logic [15:0]   data0,
    input  logic [1:0]    we0,
    output logic [15:0]   q0,
    input  logic [AW-1:0] addr1,
    output logic [15:0]   q1
);

    logic [15:0] mem [0:(1<<AW)-1];

    // Port 0: byte writes plus registered read-back
    always_ff @(posedge clk) begin
        if (we0[0]) mem[addr0][7:0]  <= data0[7:0];
        if (we0[1]) mem[addr0][15:8] <= data0[15:8];
        q0 <= mem[addr0];
    end

    // Port 1: registered scan read
    always_ff @(posedge clk) begin
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtframe_scroll_fetch.sv
// Tile fetch engine: reads the map word for the next half-tile, requests the
// ROM line and parks the decoded planes in a next buffer for the shifter.
// A new trigger before the ROM answers abandons the fetch and flags a miss.
module jtframe_scroll_fetch
    import jtframe_scroll_pkg::*;
#(
    parameter int COLW  = 6,
    parameter int ROWW  = 4,
    parameter int CODEW = 11,
    parameter int PALW  = 3,
    parameter int BPP   = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trigger,
    input  logic                         take,
    input  logic [COLW+3:0]              hf,
    input  logic [ROWW+3:0]              vs,
    output logic [COLW+ROWW-1:0]         map_addr,
    input  logic [TILE_WORD_W-1:0]       map_q,
    output logic                         rom_cs,
    output logic [CODEW+4:0]             rom_addr,
    input  logic [ROM_WORD_W-1:0]        rom_data,
    input  logic                         rom_ok,
    output logic                         miss,
    output logic [BPP*PLANE_STRIDE-1:0]  nxt_data,
    output logic [PALW-1:0]              nxt_pal,
    output logic                         nxt_valid
);

    localparam int DW = BPP*PLANE_STRIDE;

    fetch_state_t         state_q, state_d;
    logic [3:0]           vlo_q, vlo_d;
    logic                 half_q, half_d;
    logic [PALW-1:0]      pal_q, pal_d;
    logic                 hflip_q, hflip_d;
    logic                 first_q, first_d;
    logic [CODEW+4:0]     rom_addr_q, rom_addr_d;
    logic                 miss_q, miss_d;
    logic [DW-1:0]        nxt_data_q, nxt_data_d;
    logic [PALW-1:0]      nxt_pal_q, nxt_pal_d;
    logic                 nxt_valid_q, nxt_valid_d;

    logic abandon, enter_req, capture;
    logic unused_bits;

    // The RAM samples the live look-ahead address, so map_q is valid in MAP
    assign map_addr    = {vs[ROWW+3:TILE_SHIFT], hf[COLW+3:TILE_SHIFT]};
    assign rom_addr    = rom_addr_q;
    assign miss        = miss_q;
    assign nxt_data    = nxt_data_q;
    assign nxt_pal     = nxt_pal_q;
    assign nxt_valid   = nxt_valid_q;
    assign unused_bits = ^{rom_data, map_q, hf[2:0]};

    // Next-state logic: any trigger restarts MAP, a pending one counts as a miss
    always_comb begin
        state_d   = state_q;
        abandon   = 1'b0;
        enter_req = 1'b0;
        capture   = 1'b0;
        rom_cs    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) state_d = ST_MAP;
            end
            ST_MAP: begin
                if (trigger) begin
                    abandon = 1'b1;
                    state_d = ST_MAP;
                end else begin
                    enter_req = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                rom_cs = 1'b1;
                if (trigger) begin
                    abandon = 1'b1;
                    state_d = ST_MAP;
                end else if (rom_ok && !first_q) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (trigger) state_d = ST_MAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch fetch target, map fields, ROM address and next buffer
    always_comb begin
        vlo_d       = vlo_q;
        half_d      = half_q;
        pal_d       = pal_q;
        hflip_d     = hflip_q;
        rom_addr_d  = rom_addr_q;
        nxt_data_d  = nxt_data_q;
        nxt_pal_d   = nxt_pal_q;
        nxt_valid_d = nxt_valid_q;
        first_d     = enter_req;
        miss_d      = abandon;
        if (trigger) begin
            vlo_d  = vs[3:0];
            half_d = hf[HALF_SHIFT];
        end
        if (enter_req) begin
            pal_d      = map_q[TILE_PAL_MSB -: PALW];
            hflip_d    = map_q[CODEW];
            rom_addr_d = {map_q[CODEW-1:0], vlo_q, half_q ^ map_q[CODEW]};
        end
        if (capture) begin
            for (int p = 0; p < BPP; p++) begin
                nxt_data_d[p*PLANE_STRIDE +: PLANE_STRIDE] = hflip_q
                    ? rev8(rom_data[p*PLANE_STRIDE +: PLANE_STRIDE])
                    : rom_data[p*PLANE_STRIDE +: PLANE_STRIDE];
            end
            nxt_pal_d = pal_q;
        end
        if (take || abandon) begin
            nxt_valid_d = 1'b0;
        end else if (capture) begin
            nxt_valid_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vlo_q       <= '0;
            half_q      <= 1'b0;
            pal_q       <= '0;
            hflip_q     <= 1'b0;
            first_q     <= 1'b0;
            rom_addr_q  <= '0;
            miss_q      <= 1'b0;
            nxt_data_q  <= '0;
            nxt_pal_q   <= '0;
            nxt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vlo_q       <= vlo_d;
            half_q      <= half_d;
            pal_q       <= pal_d;
            hflip_q     <= hflip_d;
            first_q     <= first_d;
            rom_addr_q  <= rom_addr_d;
            miss_q      <= miss_d;
            nxt_data_q  <= nxt_data_d;
            nxt_pal_q   <= nxt_pal_d;
            nxt_valid_q <= nxt_valid_d;
        end
    end

endmodule

// File: rtl/jtframe_scroll_tiles.sv
// 16x16-tile scroll layer: CPU-visible VRAM, scroll sums, look-ahead fetch
// and a per-plane pixel shifter producing {palette, colour} per pxl_cen.
module jtframe_scroll_tiles
    import jtframe_scroll_pkg::*;
#(
    parameter int COLW  = 6,
    parameter int ROWW  = 4,
    parameter int CODEW = 11,
    parameter int PALW  = 3,
    parameter int BPP   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   flip,
    input  logic [8:0]             h,
    input  logic [7:0]             v,
    input  logic [COLW+3:0]        hscr,
    input  logic [ROWW+3:0]        vscr,
    input  logic [COLW+ROWW:0]     cpu_addr,
    input  logic                   scr_cs,
    input  logic                   cpu_wrn,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             cpu_din,
    output logic                   rom_cs,
    output logic [CODEW+4:0]       rom_addr,
    input  logic [ROM_WORD_W-1:0]  rom_data,
    input  logic                   rom_ok,
    output logic                   miss,
    output logic [PALW+BPP-1:0]    pxl
);

    localparam int HW = COLW + 4;
    localparam int VW = ROWW + 4;
    localparam int AW = COLW + ROWW;
    localparam int DW = BPP * PLANE_STRIDE;

    logic [7:0]             hx, vx;
    logic [HW-1:0]          hs, hf;
    logic [VW-1:0]          vs;
    logic                   trigger, take;
    logic [AW-1:0]          map_addr;
    logic [15:0]            map_q, cpu_q;
    logic                   cpu_wr;
    logic [1:0]             cpu_we;
    logic                   hi_q;
    logic [DW-1:0]          nxt_data;
    logic [PALW-1:0]        nxt_pal;
    logic                   nxt_valid;
    logic [DW-1:0]          shift_q, shift_d;
    logic [PALW-1:0]        spal_q, spal_d;
    logic [PALW+BPP-1:0]    pxl_q, pxl_d;
    logic [BPP-1:0]         colour;

    // Scroll sums and look-ahead target; both axes wrap at their own width
    always_comb begin
        hx = flip ? ~h[7:0] : h[7:0];
        vx = flip ? ~v : v;
        hs = hscr + HW'({h[8], hx});
        vs = vscr + VW'(vx);
        hf = hs + HW'(8);
    end

    assign trigger = pxl_cen & (hs[2:0] == 3'd0);
    assign take    = pxl_cen & (hs[2:0] == 3'd7);

    assign cpu_wr  = scr_cs & ~cpu_wrn;
    assign cpu_we  = {cpu_wr & cpu_addr[AW], cpu_wr & ~cpu_addr[AW]};
    assign cpu_din = hi_q ? cpu_q[15:8] : cpu_q[7:0];
    assign pxl     = pxl_q;

    jtframe_dual_ram16 #(.AW(AW)) u_vram (
        .clk   (clk),
        .addr0 (cpu_addr[AW-1:0]),
        .data0 ({cpu_dout, cpu_dout}),
        .we0   (cpu_we),
        .q0    (cpu_q),
        .addr1 (map_addr),
        .q1    (map_q)
    );

    jtframe_scroll_fetch #(
        .COLW (COLW), .ROWW (ROWW), .CODEW(CODEW), .PALW(PALW), .BPP(BPP)
    ) u_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .take      (take),
        .hf        (hf),
        .vs        (vs),
        .map_addr  (map_addr),
        .map_q     (map_q),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok),
        .miss      (miss),
        .nxt_data  (nxt_data),
        .nxt_pal   (nxt_pal),
        .nxt_valid (nxt_valid)
    );

    // Byte-lane select for CPU read-back, aligned with the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hi_q <= 1'b0;
        else        hi_q <= cpu_addr[AW];
    end

    // Shifter: emit the current column, then load the next half or advance
    always_comb begin
        for (int p = 0; p < BPP; p++) begin
            colour[p] = shift_q[p*PLANE_STRIDE];
        end
        pxl_d   = pxl_q;
        shift_d = shift_q;
        spal_d  = spal_q;
        if (pxl_cen) begin
            pxl_d = {spal_q, colour};
            if (hs[2:0] == 3'd7) begin
                shift_d = nxt_valid ? nxt_data : '0;
                spal_d  = nxt_valid ? nxt_pal  : '0;
            end else begin
                for (int p = 0; p < BPP; p++) begin
                    shift_d[p*PLANE_STRIDE +: PLANE_STRIDE] =
                        {1'b0, shift_q[p*PLANE_STRIDE+1 +: PLANE_STRIDE-1]};
                end
            end
        end
    end

    // Shifter and pixel output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            spal_q  <= '0;
            pxl_q   <= '0;
        end else begin
            shift_q <= shift_d;
            spal_q  <= spal_d;
            pxl_q   <= pxl_d;
        end
    end

endmodule

// File: tb/tb_jtframe_scroll_tiles.sv
// Directed bench for jtframe_scroll_tiles: basic scan, hflip, scroll wrap,
// screen flip, slow ROM misses and asynchronous reset during a request.
module tb_jtframe_scroll_tiles;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        flip = 1'b0;
    logic [8:0]  h = '0;
    logic [7:0]  v = '0;
    logic [9:0]  hscr = '0;
    logic [7:0]  vscr = '0;
    logic [10:0] cpu_addr = '0;
    logic        scr_cs = 1'b0;
    logic        cpu_wrn = 1'b1;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        miss;
    logic [5:0]  pxl;

    logic [31:0] romLo = '0;
    logic [31:0] romHi = '0;
    int          romLatency = 0;
    int          romWait = 0;
    int          missCount = 0;
    int          stabErr = 0;
    logic        prevCs = 1'b0;
    logic [15:0] prevAddr = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_addr[0] ? romHi : romLo;
    assign rom_ok   = (romWait >= romLatency);

    jtframe_scroll_tiles #(
        .COLW(6), .ROWW(4), .CODEW(11), .PALW(3), .BPP(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .flip     (flip),
        .h        (h),
        .v        (v),
        .hscr     (hscr),
        .vscr     (vscr),
        .cpu_addr (cpu_addr),
        .scr_cs   (scr_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .miss     (miss),
        .pxl      (pxl)
    );

    // ROM latency model: counts clocks the request has been held
    always @(posedge clk) begin
        romWait <= rom_cs ? romWait + 1 : 0;
    end

    // Miss pulse counter and ROM address stability monitor
    always @(posedge clk) begin
        if (miss) missCount <= missCount + 1;
        prevCs   <= rom_cs;
        prevAddr <= rom_addr;
        if (rom_cs && prevCs && (rom_addr !== prevAddr)) stabErr <= stabErr + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel: pxl_cen for one clk with h presented, then idle clocks
    task automatic applyStimulus(input logic [8:0] hv);
        @(negedge clk);
        h       = hv;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cpuWrite(input logic [9:0] a, input logic [15:0] w);
        @(negedge clk);
        cpu_addr = {1'b0, a};
        cpu_dout = w[7:0];
        scr_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        @(negedge clk);
        cpu_addr = {1'b1, a};
        cpu_dout = w[15:8];
        @(negedge clk);
        scr_cs   = 1'b0;
        cpu_wrn  = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        pxl_cen = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [5:0] expBasic(input int hv);
        if (hv < 8)  return 6'h00;
        if (hv < 16) return 6'h2D;
        if (hv < 20) return 6'h29;
        if (hv < 24) return 6'h28;
        return 6'h05;
    endfunction

    // Tile 0x005 pal 5 at (0,0), tile 0 at (0,1); scan from hs=1016
    task automatic scanBasic(input string tag);
        cpuWrite(10'd0, 16'hA005);
        cpuWrite(10'd1, 16'h0000);
        romLo      = 32'h00FF00FF;
        romHi      = 32'h0000000F;
        romLatency = 0;
        hscr = 10'd1016;
        vscr = 8'd0;
        flip = 1'b0;
        v    = 8'd0;
        for (int i = 0; i <= 24; i++) begin
            applyStimulus(9'(i));
            checkOutput($sformatf("%s pxl h=%0d", tag, i), 32'(pxl), 32'(expBasic(i)));
            if (i == 0) checkOutput({tag, " rom_addr h0"}, 32'(rom_addr), 32'h00A0);
            if (i == 8) checkOutput({tag, " rom_addr h8"}, 32'(rom_addr), 32'h00A1);
        end
    endtask

    initial begin
        int m0;
        // Reset values while reset is held
        repeat (3) @(negedge clk);
        checkOutput("reset pxl", 32'(pxl), 32'h0);
        checkOutput("reset rom_cs", 32'(rom_cs), 32'h0);
        checkOutput("reset rom_addr", 32'(rom_addr), 32'h0);
        checkOutput("reset miss", 32'(miss), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-latency ROM basic scan
        doReset();
        scanBasic("basic");
        checkOutput("basic no miss", 32'(missCount), 32'h0);

        // CPU byte read-back
        @(negedge clk);
        cpu_addr = {1'b1, 10'd0};
        repeat (2) @(negedge clk);
        checkOutput("cpu_din hi", 32'(cpu_din), 32'hA0);
        cpu_addr = {1'b0, 10'd0};
        repeat (2) @(negedge clk);
        checkOutput("cpu_din lo", 32'(cpu_din), 32'h05);

        // hflip: set pixel moves from column 0 to column 15
        cpuWrite(10'd0, 16'h0807);
        cpuWrite(10'd1, 16'h0000);
        romLo = 32'h00000001;
        romHi = 32'h00000000;
        doReset();
        for (int i = 0; i <= 24; i++) begin
            applyStimulus(9'(i));
            checkOutput($sformatf("hflip pxl h=%0d", i), 32'(pxl), (i >= 23) ? 32'h01 : 32'h00);
            if (i == 0) checkOutput("hflip rom_addr h0", 32'(rom_addr), 32'h00E1);
            if (i == 8) checkOutput("hflip rom_addr h8", 32'(rom_addr), 32'h00E0);
        end

        // Scroll wrap in both axes
        cpuWrite(10'd960, 16'h0010);
        cpuWrite(10'd0,   16'h0020);
        cpuWrite(10'd1,   16'h0021);
        doReset();
        hscr = 10'd1020;
        vscr = 8'd250;
        v    = 8'd0;
        applyStimulus(9'd4);
        checkOutput("wrap row15 col0", 32'(rom_addr), 32'h0215);
        v = 8'd6;
        applyStimulus(9'd4);
        checkOutput("wrap row0 col0", 32'(rom_addr), 32'h0401);
        applyStimulus(9'd12);
        checkOutput("wrap row0 col1", 32'(rom_addr), 32'h0420);

        // Screen flip mirrors the counters
        cpuWrite(10'd976, 16'h0033);
        doReset();
        hscr = 10'd1;
        vscr = 8'd0;
        flip = 1'b1;
        v    = 8'd0;
        applyStimulus(9'd0);
        checkOutput("flip h0", 32'(rom_addr), 32'h067F);
        flip = 1'b0;
        applyStimulus(9'd15);
        checkOutput("noflip h15", 32'(rom_addr), 32'h0421);
        v = 8'd255;
        applyStimulus(9'd255);
        checkOutput("noflip h255", 32'(rom_addr), 32'h067F);

        // Slow ROM: every fetch abandoned, halves blank
        doReset();
        romLatency = 80;
        hscr = 10'd1016;
        vscr = 8'd0;
        v    = 8'd0;
        m0   = missCount;
        for (int i = 0; i <= 23; i++) begin
            applyStimulus(9'(i));
            checkOutput($sformatf("slow pxl h=%0d", i), 32'(pxl), 32'h0);
        end
        checkOutput("slow miss count", 32'(missCount - m0), 32'd2);
        checkOutput("slow rom_cs", 32'(rom_cs), 32'h1);
        checkOutput("slow rom_addr", 32'(rom_addr), 32'h0420);
        checkOutput("rom_addr stable", 32'(stabErr), 32'h0);

        // Asynchronous reset while the request is outstanding
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rom_cs", 32'(rom_cs), 32'h0);
        checkOutput("async rom_addr", 32'(rom_addr), 32'h0);
        checkOutput("async pxl", 32'(pxl), 32'h0);
        checkOutput("async miss", 32'(miss), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scanBasic("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
